bmc_spi_model: RTL and testbench

Behavioural-synthesizable model of the board management controller (BMC) side of the FPGA↔BMC SPI link, used in the card-level environment. It is the SPI target on the egress link, where the FPGA is master: it holds a small 32-bit register file that the FPGA reads and writes. It is the SPI master on the ingress link, where it issues read and write frames to the FPGA from a simple local command port. All SPI pins are sampled and driven from one system clock; external SPI clocks are oversampled.

---
 rtl/bmc_spi_model.sv | 276 +++++++++++++++++++++++++++
 tb/tb_bmc_spi_model.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_spi_model.sv
// bmc_spi_model: board management controller side of the FPGA<->BMC SPI link.
//   Egress link: SPI target with a small 32-bit register file. The FPGA is master.
//   Ingress link: SPI master. It issues read/write frames from a local command port.
// Frame (both links): SPI mode 0, MSB first, 48 bits = opcode[8], addr[8], data[32].
// Ports:
//   clk, rst_n                      single clock, synchronous active-low reset
//   egrs_spi_clk/csn/mosi -> miso   egress target pins (oversampled)
//   ingr_spi_clk/csn/mosi <- miso   ingress master pins
//   cmd_valid/ready/write/addr/wdata  ingress command handshake
//   rsp_valid, rsp_rdata            completion pulse and held read data
module bmc_spi_model #(
  parameter int          CLK_DIV  = 4,
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] BMC_ID   = 32'h0B3C_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        egrs_spi_clk,
  input  logic        egrs_spi_csn,
  input  logic        egrs_spi_mosi,
  output logic        egrs_spi_miso,
  output logic        ingr_spi_clk,
  output logic        ingr_spi_csn,
  output logic        ingr_spi_mosi,
  input  logic        ingr_spi_miso,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata
);
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // ---------------- Egress target ----------------
  // Bits [1:0] of each chain form the 2-flop synchronizer; bit [2] is the
  // previous synchronized value used for edge detection.
  logic [2:0]  e_sclk_q, e_sclk_d;
  logic [2:0]  e_csn_q, e_csn_d;
  logic [1:0]  e_mosi_q, e_mosi_d;
  logic [5:0]  e_cnt_q, e_cnt_d;
  logic [47:0] e_sh_q, e_sh_d;
  logic        e_rd_act_q, e_rd_act_d;
  logic [31:0] e_rd_sh_q, e_rd_sh_d;
  logic        e_miso_q, e_miso_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic        sclk_rise, sclk_fall, csn_fall;
  logic [47:0] e_new_sh;
  logic [31:0] e_rd_word;

  always_comb begin
    e_sclk_d   = {e_sclk_q[1:0], egrs_spi_clk};
    e_csn_d    = {e_csn_q[1:0], egrs_spi_csn};
    e_mosi_d   = {e_mosi_q[0], egrs_spi_mosi};
    e_cnt_d    = e_cnt_q;
    e_sh_d     = e_sh_q;
    e_rd_act_d = e_rd_act_q;
    e_rd_sh_d  = e_rd_sh_q;
    e_miso_d   = e_miso_q;
    regs_d     = regs_q;

    sclk_rise = e_sclk_q[1] & ~e_sclk_q[2];
    sclk_fall = ~e_sclk_q[1] & e_sclk_q[2];
    csn_fall  = ~e_csn_q[1] & e_csn_q[2];
    e_new_sh  = {e_sh_q[46:0], e_mosi_q[1]};

    // Read word for the address that completes at rise 16.
    e_rd_word = '0;
    if (e_new_sh[7:0] == 8'h00) e_rd_word = BMC_ID;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (int'(e_new_sh[7:0]) == i) e_rd_word = regs_q[i];
    end

    if (csn_fall) begin
      e_cnt_d    = '0;
      e_rd_act_d = 1'b0;
      e_miso_d   = 1'b0;
    end else if (e_csn_q[1]) begin
      // Deselected: any partial frame is dropped without side effects.
      e_rd_act_d = 1'b0;
      e_miso_d   = 1'b0;
    end else begin
      if (sclk_rise && (e_cnt_q != 6'd48)) begin
        e_sh_d  = e_new_sh;
        e_cnt_d = e_cnt_q + 6'd1;
        if ((e_cnt_q == 6'd15) && (e_new_sh[15:8] == OP_READ)) begin
          e_rd_act_d = 1'b1;
          e_rd_sh_d  = e_rd_word;
        end
        if ((e_cnt_q == 6'd47) && (e_new_sh[47:40] == OP_WRITE)) begin
          // Address 0 and out-of-range addresses match no entry.
          for (int i = 1; i < NUM_REGS; i++) begin
            if (int'(e_new_sh[39:32]) == i) regs_d[i] = e_new_sh[31:0];
          end
        end
      end
      if (sclk_fall && e_rd_act_q) begin
        // Falls after rises 16..47 carry data bits 31..0; later falls idle low.
        if (e_cnt_q != 6'd48) begin
          e_miso_d  = e_rd_sh_q[31];
          e_rd_sh_d = {e_rd_sh_q[30:0], 1'b0};
        end else begin
          e_miso_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_sclk_q   <= 3'b000;
      e_csn_q    <= 3'b111;
      e_mosi_q   <= 2'b00;
      e_cnt_q    <= '0;
      e_sh_q     <= '0;
      e_rd_act_q <= 1'b0;
      e_rd_sh_q  <= '0;
      e_miso_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      e_sclk_q   <= e_sclk_d;
      e_csn_q    <= e_csn_d;
      e_mosi_q   <= e_mosi_d;
      e_cnt_q    <= e_cnt_d;
      e_sh_q     <= e_sh_d;
      e_rd_act_q <= e_rd_act_d;
      e_rd_sh_q  <= e_rd_sh_d;
      e_miso_q   <= e_miso_d;
      regs_q     <= regs_d;
    end
  end

  // Gate with the raw pin so MISO is low the moment the master deselects.
  assign egrs_spi_miso = e_miso_q & ~egrs_spi_csn;

  // ---------------- Ingress master ----------------
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_LO, ST_HI, ST_HOLD, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic [47:0]      tx_sh_q, tx_sh_d;
  logic             is_wr_q, is_wr_d;
  logic             i_sclk_q, i_sclk_d;
  logic             i_csn_q, i_csn_d;
  logic             i_mosi_q, i_mosi_d;
  logic [31:0]      rx_sh_q, rx_sh_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             div_done;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_sh_d     = tx_sh_q;
    is_wr_d     = is_wr_q;
    i_sclk_d    = i_sclk_q;
    i_csn_d     = i_csn_q;
    i_mosi_d    = i_mosi_q;
    rx_sh_d     = rx_sh_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    div_done    = (div_q == DIV_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tx_sh_d = {(cmd_write ? OP_WRITE : OP_READ), cmd_addr,
                     (cmd_write ? cmd_wdata : 32'h0)};
          is_wr_d = cmd_write;
          i_csn_d = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        div_d = div_q + 1'b1;
        if (div_done) begin
          div_d    = '0;
          i_mosi_d = tx_sh_q[47];
          tx_sh_d  = {tx_sh_q[46:0], 1'b0};
          state_d  = ST_LO;
        end
      end
      ST_LO: begin
        div_d = div_q + 1'b1;
        if (div_done) begin
          div_d    = '0;
          i_sclk_d = 1'b1;
          // Bits 17..48 (0-based 16..47) carry the target's read data.
          if (bit_q >= 6'd16) rx_sh_d = {rx_sh_q[30:0], ingr_spi_miso};
          state_d  = ST_HI;
        end
      end
      ST_HI: begin
        div_d = div_q + 1'b1;
        if (div_done) begin
          div_d    = '0;
          i_sclk_d = 1'b0;
          if (bit_q == 6'd47) begin
            i_mosi_d = 1'b0;
            state_d  = ST_HOLD;
          end else begin
            bit_d    = bit_q + 6'd1;
            i_mosi_d = tx_sh_q[47];
            tx_sh_d  = {tx_sh_q[46:0], 1'b0};
            state_d  = ST_LO;
          end
        end
      end
      ST_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_done) begin
          div_d       = '0;
          i_csn_d     = 1'b1;
          rsp_valid_d = 1'b1;
          if (!is_wr_q) rsp_rdata_d = rx_sh_q;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        // Keeps CSN high for at least CLK_DIV cycles between frames.
        div_d = div_q + 1'b1;
        if (div_done) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_sh_q     <= '0;
      is_wr_q     <= 1'b0;
      i_sclk_q    <= 1'b0;
      i_csn_q     <= 1'b1;
      i_mosi_q    <= 1'b0;
      rx_sh_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_sh_q     <= tx_sh_d;
      is_wr_q     <= is_wr_d;
      i_sclk_q    <= i_sclk_d;
      i_csn_q     <= i_csn_d;
      i_mosi_q    <= i_mosi_d;
      rx_sh_q     <= rx_sh_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign ingr_spi_clk  = i_sclk_q;
  assign ingr_spi_csn  = i_csn_q;
  assign ingr_spi_mosi = i_mosi_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_bmc_spi_model.sv
// tb_bmc_spi_model: loops the ingress master onto the egress target of one
// instance (CLK_DIV = 4) and checks responses against a scoreboard; a raw mode
// lets the bench drive the egress pins directly.
module tb_bmc_spi_model;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_valid, cmd_write, cmd_ready, rsp_valid;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata, rsp_rdata;
  logic        egrs_spi_clk, egrs_spi_csn, egrs_spi_mosi, egrs_spi_miso;
  logic        ingr_spi_clk, ingr_spi_csn, ingr_spi_mosi, ingr_spi_miso;
  logic        raw_mode, raw_clk, raw_csn, raw_mosi;

  assign egrs_spi_clk  = raw_mode ? raw_clk  : ingr_spi_clk;
  assign egrs_spi_csn  = raw_mode ? raw_csn  : ingr_spi_csn;
  assign egrs_spi_mosi = raw_mode ? raw_mosi : ingr_spi_mosi;
  assign ingr_spi_miso = egrs_spi_miso;

  bmc_spi_model #(.CLK_DIV(4), .NUM_REGS(16), .BMC_ID(32'h0B3C_0001)) dut (
    .clk(clk), .rst_n(rst_n),
    .egrs_spi_clk(egrs_spi_clk), .egrs_spi_csn(egrs_spi_csn),
    .egrs_spi_mosi(egrs_spi_mosi), .egrs_spi_miso(egrs_spi_miso),
    .ingr_spi_clk(ingr_spi_clk), .ingr_spi_csn(ingr_spi_csn),
    .ingr_spi_mosi(ingr_spi_mosi), .ingr_spi_miso(ingr_spi_miso),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; int acc; } exp_t;
  exp_t sb[$];

  typedef struct { logic wr; logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;
  vec_t vecs[13];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response / CSN monitor
  logic csn_prev = 1'b1;
  bit   have_rise = 0;
  bit   skip_len = 0;
  int   csn_fall_cyc = 0, csn_rise_cyc = 0, rsp_count = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      rsp_count++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check32("rsp_rdata", rsp_rdata, e.rdata);
        check32("rsp_latency", 32'(cyc - e.acc), 32'd393);
      end
    end
    if (csn_prev && !ingr_spi_csn) begin
      if (have_rise) begin
        checks++;
        if (cyc - csn_rise_cyc < 4) begin
          errors++;
          $display("FAIL csn_gap: got %0d cycles expected >= 4", cyc - csn_rise_cyc);
        end
      end
      csn_fall_cyc = cyc;
    end
    if (!csn_prev && ingr_spi_csn) begin
      if (!skip_len) check32("csn_low_len", 32'(cyc - csn_fall_cyc), 32'd392);
      csn_rise_cyc = cyc;
      have_rise = 1;
    end
    csn_prev = ingr_spi_csn;
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
    bit ok;
    exp_t e;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 2000 cycles");
    end else begin
      e.rdata = exp; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drop_valid();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_egrs_miso"}, {31'b0, egrs_spi_miso}, 32'd0);
    check32({tag, "_ingr_clk"},  {31'b0, ingr_spi_clk},  32'd0);
    check32({tag, "_ingr_csn"},  {31'b0, ingr_spi_csn},  32'd1);
    check32({tag, "_ingr_mosi"}, {31'b0, ingr_spi_mosi}, 32'd0);
    check32({tag, "_cmd_ready"}, {31'b0, cmd_ready},     32'd1);
    check32({tag, "_rsp_valid"}, {31'b0, rsp_valid},     32'd0);
    check32({tag, "_rsp_rdata"}, rsp_rdata,              32'd0);
  endtask

  // Bit-bangs one egress frame of nbits; rx collects MISO just before rises 17..48.
  task automatic raw_frame(input logic [7:0] op, input logic [7:0] a, input logic [31:0] d,
                           input int nbits, output logic [31:0] rx);
    logic [47:0] fr;
    fr = {op, a, d};
    rx = '0;
    @(posedge clk); #1 raw_csn = 1'b0;
    repeat (5) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      #1 raw_clk = 1'b0; raw_mosi = fr[47-i];
      repeat (4) @(posedge clk);
      @(negedge clk);
      if (i >= 16) rx = {rx[30:0], egrs_spi_miso};
      @(posedge clk); #1 raw_clk = 1'b1;
      repeat (5) @(posedge clk);
    end
    #1 raw_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1 raw_csn = 1'b1; raw_mosi = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish expected finish before 900us");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    logic [31:0] rx;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    raw_mode = 1'b0; raw_clk = 1'b0; raw_csn = 1'b1; raw_mosi = 1'b0;

    vecs[0]  = '{1'b0, 8'h03, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 8'h05, 32'hA5A5_1234, 32'h0000_0000};
    vecs[2]  = '{1'b0, 8'h05, 32'h0000_0000, 32'hA5A5_1234};
    vecs[3]  = '{1'b0, 8'h00, 32'h0000_0000, 32'h0B3C_0001};
    vecs[4]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0B3C_0001};
    vecs[5]  = '{1'b0, 8'h00, 32'h0000_0000, 32'h0B3C_0001};
    vecs[6]  = '{1'b0, 8'h20, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{1'b1, 8'h20, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[8]  = '{1'b1, 8'h25, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[9]  = '{1'b0, 8'h05, 32'h0000_0000, 32'hA5A5_1234};
    vecs[10] = '{1'b1, 8'h0F, 32'h5A5A_0F0F, 32'hA5A5_1234};
    vecs[11] = '{1'b0, 8'h0F, 32'h0000_0000, 32'h5A5A_0F0F};
    vecs[12] = '{1'b0, 8'h10, 32'h0000_0000, 32'h0000_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      drop_valid();
      wait_done();
    end

    // Back-to-back commands with cmd_valid held high throughout.
    cnt0 = rsp_count;
    send(1'b1, 8'h07, 32'h1234_5678, 32'h0000_0000);
    send(1'b0, 8'h07, 32'h0000_0000, 32'h1234_5678);
    drop_valid();
    wait_done();
    check32("busy_rsp_count", 32'(rsp_count - cnt0), 32'd2);

    // Reset at bit 30 of a write to address 7.
    send(1'b1, 8'h07, 32'h1111_1111, 32'h0000_0000);
    drop_valid();
    repeat (236) @(negedge clk);
    skip_len = 1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    cnt0 = rsp_count;
    repeat (400) @(negedge clk);
    check32("abort_no_rsp", 32'(rsp_count - cnt0), 32'd0);
    skip_len = 0;
    send(1'b0, 8'h07, 32'h0000_0000, 32'h0000_0000);
    drop_valid();
    wait_done();

    // Direct egress frames: full write, read back, aborted write, read back.
    raw_mode = 1'b1;
    raw_frame(8'h02, 8'h09, 32'hCAFE_F00D, 48, rx);
    raw_frame(8'h03, 8'h09, 32'h0000_0000, 48, rx);
    check32("raw_read9", rx, 32'hCAFE_F00D);
    raw_frame(8'h02, 8'h09, 32'h0000_0000, 40, rx);
    check32("raw_abort_miso", {31'b0, egrs_spi_miso}, 32'd0);
    raw_frame(8'h03, 8'h09, 32'h0000_0000, 48, rx);
    check32("raw_read9_after_abort", rx, 32'hCAFE_F00D);
    raw_frame(8'h03, 8'h00, 32'h0000_0000, 48, rx);
    check32("raw_read_id", rx, 32'h0B3C_0001);
    raw_mode = 1'b0;
    repeat (10) @(posedge clk);
    send(1'b0, 8'h09, 32'h0000_0000, 32'hCAFE_F00D);
    drop_valid();
    wait_done();

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
